// File: rtl/panel_reader.sv
// panel_reader: front-panel input block. Slide switches are staged into a
// 32-bit word through debounced L/R/D buttons and committed with C over a
// valid/ready handshake; a commit is discarded (drop_o) while the previous word
// is still unaccepted.
// Optional feature macro: PANEL_READER_SW_DEBOUNCE_EN (debounce every switch bit
// and load the debounced levels instead of the merely synchronized ones).
module panel_reader #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] sw_i,
  input  logic [3:0]  btn_i,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic [31:0] preview_o,
  output logic        drop_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef PANEL_READER_SW_DEBOUNCE_EN
  // Buttons occupy bits [3:0], switches bits [19:4] of the debounced vector.
  localparam int NDB = 20;
`else
  localparam int NDB = 4;
`endif

  logic [15:0]    sw_meta_reg;
  logic [15:0]    sw_sync_reg;
  logic [3:0]     btn_meta_reg;
  logic [3:0]     btn_sync_reg;
  logic [NDB-1:0] db_in;
  logic [NDB-1:0] db_level;
  logic [3:0]     btn_prev_reg;
  logic [3:0]     press;
  logic [15:0]    sw_load;
  logic [15:0]    hi_next;
  logic [15:0]    lo_next;

  // Two-flop synchronizers for every asynchronous panel input.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
    end else begin
      sw_meta_reg  <= sw_i;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= btn_i;
      btn_sync_reg <= btn_meta_reg;
    end
  end

`ifdef PANEL_READER_SW_DEBOUNCE_EN
  assign db_in   = {sw_sync_reg, btn_sync_reg};
  assign sw_load = db_level[19:4];
`else
  assign db_in   = btn_sync_reg;
  assign sw_load = sw_sync_reg;
`endif

  generate
    for (genvar gi = 0; gi < NDB; gi++) begin : g_db
      logic [CW-1:0] cnt_reg;
      logic          level_reg;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (db_in[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_reg   <= '0;
          level_reg <= ~level_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign db_level[gi] = level_reg;
    end
  endgenerate

  // Previous debounced button levels, for rising-edge (press) detection.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      btn_prev_reg <= '0;
    end else begin
      btn_prev_reg <= db_level[3:0];
    end
  end

  // Press pulses: one cycle on the debounced 0->1 edge; releases are ignored.
  assign press = db_level[3:0] & ~btn_prev_reg;

  // Staging update; clear wins over loads in the same cycle.
  always_comb begin
    hi_next = preview_o[31:16];
    lo_next = preview_o[15:0];
    if (press[3]) begin
      hi_next = '0;
      lo_next = '0;
    end else begin
      if (press[0]) hi_next = sw_load;
      if (press[1]) lo_next = sw_load;
    end
  end

  // Staging word register; it is shown directly on the display.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      preview_o <= '0;
    end else begin
      preview_o <= {hi_next, lo_next};
    end
  end

  // Commit handshake: commit the post-update staging word, or drop it when
  // the consumer still holds off the previous word.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      drop_o  <= 1'b0;
    end else begin
      drop_o <= 1'b0;
      if (press[2]) begin
        if (!valid_o || ready_i) begin
          data_o  <= {hi_next, lo_next};
          valid_o <= 1'b1;
        end else begin
          drop_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
